// File: rtl/vpu_req_issuer_pkg.sv
// Shared widths, command record and issuer FSM encoding for the VPU request issuer.
package vpu_req_issuer_pkg;

    localparam int unsigned OPCODE_W = 8;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned LEN_W    = 16;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [ADDR_W-1:0]   src0;
        logic [ADDR_W-1:0]   src1;
        logic [ADDR_W-1:0]   src2;
        logic [ADDR_W-1:0]   dst;
        logic [LEN_W-1:0]    len;
    } vpu_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/vpu_req_issuer_fifo.sv
// Synchronous command FIFO of vpu_cmd_t; registered storage, head visible one cycle after push.
module vpu_cmd_fifo
    import vpu_req_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  vpu_cmd_t push_data,
    input  logic     pop,
    output vpu_cmd_t pop_data,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty when the indices match.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    vpu_cmd_t       mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/vpu_req_issuer.sv
// Buffers host vector commands and issues them to the VPU one row-chunk at a time,
// waiting for writeback-done between chunks.
module vpu_req_issuer
    import vpu_req_issuer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [OPCODE_W-1:0] cmd_opcode_i,
    input  logic [ADDR_W-1:0]   cmd_src0_i,
    input  logic [ADDR_W-1:0]   cmd_src1_i,
    input  logic [ADDR_W-1:0]   cmd_src2_i,
    input  logic [ADDR_W-1:0]   cmd_dst_i,
    input  logic [LEN_W-1:0]    cmd_len_i,
    output logic                req_valid_o,
    input  logic                req_ready_i,
    output logic [OPCODE_W-1:0] req_opcode_o,
    output logic [ADDR_W-1:0]   req_src0_o,
    output logic [ADDR_W-1:0]   req_src1_o,
    output logic [ADDR_W-1:0]   req_src2_o,
    output logic [ADDR_W-1:0]   req_dst_o,
    output logic                req_last_o,
    input  logic                vpu_done_i,
    output logic                cmd_done_o,
    output logic                busy_o,
    output logic                err_o
);

    issuer_state_t    state;
    logic [LEN_W-1:0] remaining;
    vpu_cmd_t         push_cmd;
    vpu_cmd_t         head_cmd;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    assign push_cmd = '{opcode: cmd_opcode_i, src0: cmd_src0_i, src1: cmd_src1_i,
                        src2: cmd_src2_i, dst: cmd_dst_i, len: cmd_len_i};

    assign cmd_ready_o = !fifo_full && !rst;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign fifo_pop    = (state == IDLE) && !fifo_empty;

    // Derived purely from flops: state register and FIFO pointer registers.
    assign busy_o = (state != IDLE) || !fifo_empty;

    vpu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remaining    <= '0;
            req_valid_o  <= 1'b0;
            req_opcode_o <= '0;
            req_src0_o   <= '0;
            req_src1_o   <= '0;
            req_src2_o   <= '0;
            req_dst_o    <= '0;
            req_last_o   <= 1'b0;
            cmd_done_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            cmd_done_o <= 1'b0;
            // A done arriving with the ISSUE handshake still counts as unexpected.
            if (vpu_done_i && (state != WAIT)) begin
                err_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        req_opcode_o <= head_cmd.opcode;
                        req_src0_o   <= head_cmd.src0;
                        req_src1_o   <= head_cmd.src1;
                        req_src2_o   <= head_cmd.src2;
                        req_dst_o    <= head_cmd.dst;
                        remaining    <= head_cmd.len;
                        if (head_cmd.len == '0) begin
                            cmd_done_o <= 1'b1;
                        end else begin
                            req_valid_o <= 1'b1;
                            req_last_o  <= (head_cmd.len == LEN_W'(1));
                            state       <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (req_ready_i) begin
                        req_valid_o <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (vpu_done_i) begin
                        if (remaining == LEN_W'(1)) begin
                            cmd_done_o <= 1'b1;
                            req_last_o <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            remaining   <= remaining - LEN_W'(1);
                            req_src0_o  <= req_src0_o + ADDR_W'(1);
                            req_src1_o  <= req_src1_o + ADDR_W'(1);
                            req_src2_o  <= req_src2_o + ADDR_W'(1);
                            req_dst_o   <= req_dst_o + ADDR_W'(1);
                            req_last_o  <= (remaining == LEN_W'(2));
                            req_valid_o <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_req_issuer.sv
// Directed self-checking bench for vpu_req_issuer with hand-computed expected values.
module tb_vpu_req_issuer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = '0;
    logic [15:0] cmd_src0 = '0;
    logic [15:0] cmd_src1 = '0;
    logic [15:0] cmd_src2 = '0;
    logic [15:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [7:0]  req_opcode;
    logic [15:0] req_src0;
    logic [15:0] req_src1;
    logic [15:0] req_src2;
    logic [15:0] req_dst;
    logic        req_last;
    logic        man_done = 1'b0;
    logic        auto_done = 1'b0;
    logic        vpu_done;
    logic        cmd_done;
    logic        busy;
    logic        err;

    assign vpu_done = man_done | auto_done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit auto_vpu = 1'b0;
    int resp_dly = 2;
    int cd = 0;
    logic [15:0] hs_src0 [$];
    logic        hs_last [$];

    vpu_req_issuer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_src0_i   (cmd_src0),
        .cmd_src1_i   (cmd_src1),
        .cmd_src2_i   (cmd_src2),
        .cmd_dst_i    (cmd_dst),
        .cmd_len_i    (cmd_len),
        .req_valid_o  (req_valid),
        .req_ready_i  (req_ready),
        .req_opcode_o (req_opcode),
        .req_src0_o   (req_src0),
        .req_src1_o   (req_src1),
        .req_src2_o   (req_src2),
        .req_dst_o    (req_dst),
        .req_last_o   (req_last),
        .vpu_done_i   (vpu_done),
        .cmd_done_o   (cmd_done),
        .busy_o       (busy),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    // Negedge monitor: counts done pulses, logs handshakes, and models a VPU that
    // answers each accepted chunk resp_dly edges later when auto_vpu is set.
    always @(negedge clk) begin
        if (cmd_done) done_cnt++;
        auto_done = auto_vpu && (cd == 1);
        if (cd > 0) cd--;
        if (req_valid && req_ready) begin
            hs_src0.push_back(req_src0);
            hs_last.push_back(req_last);
            if (auto_vpu) cd = resp_dly;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] op, input logic [15:0] s0, input logic [15:0] s1,
                        input logic [15:0] s2, input logic [15:0] d, input logic [15:0] len);
        bit taken = 1'b0;
        cmd_opcode = op;
        cmd_src0   = s0;
        cmd_src1   = s1;
        cmd_src2   = s2;
        cmd_dst    = d;
        cmd_len    = len;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 200 && !taken; i++) begin
            if (cmd_ready) taken = 1'b1;
            tick();
        end
        cmd_valid = 1'b0;
        if (!taken) check_eq("push_timeout", 32'(taken), 32'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick();
        check_eq(tag, done_cnt, target);
    endtask

    initial begin
        int base;

        // Reset state
        tick();
        tick();
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_req_valid", 32'(req_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_cmd_done", 32'(cmd_done), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Single command, len 3, VPU done 4 edges after each accept
        base = done_cnt;
        req_ready = 1'b1;
        push(8'h03, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'd3);
        check_eq("lat_not_yet", 32'(req_valid), 32'd0);
        tick();
        check_eq("lat_valid", 32'(req_valid), 32'd1);
        check_eq("t1_opcode", 32'(req_opcode), 32'h03);
        for (int k = 0; k < 3; k++) begin
            check_eq("t1_src0", 32'(req_src0), 32'h10 + k);
            check_eq("t1_src1", 32'(req_src1), 32'h20 + k);
            check_eq("t1_src2", 32'(req_src2), 32'h30 + k);
            check_eq("t1_dst", 32'(req_dst), 32'h40 + k);
            check_eq("t1_last", 32'(req_last), (k == 2) ? 32'd1 : 32'd0);
            tick();
            check_eq("t1_wait_novalid", 32'(req_valid), 32'd0);
            tick();
            tick();
            tick();
            man_done = 1'b1;
            tick();
            man_done = 1'b0;
            if (k < 2) begin
                check_eq("t1_turnaround", 32'(req_valid), 32'd1);
            end else begin
                check_eq("t1_cmd_done", 32'(cmd_done), 32'd1);
                check_eq("t1_final_novalid", 32'(req_valid), 32'd0);
            end
        end
        tick();
        check_eq("t1_done_pulse_end", 32'(cmd_done), 32'd0);
        check_eq("t1_done_count", done_cnt - base, 32'd1);
        check_eq("t1_busy_idle", 32'(busy), 32'd0);
        check_eq("t1_err", 32'(err), 32'd0);

        // FIFO fill with VPU stalled, backpressure hold, then in-order drain
        hs_src0.delete();
        hs_last.delete();
        base = done_cnt;
        req_ready = 1'b0;
        auto_vpu = 1'b1;
        resp_dly = 2;
        for (int i = 0; i < 5; i++) begin
            push(8'h10 + 8'(i), 16'h0100 + 16'(i), 16'h0, 16'h0, 16'h0200 + 16'(i), 16'd1);
        end
        check_eq("t2_fifo_full", 32'(cmd_ready), 32'd0);
        check_eq("t2_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check_eq("t2_bp_valid", 32'(req_valid), 32'd1);
            check_eq("t2_bp_src0", 32'(req_src0), 32'h0100);
            check_eq("t2_bp_dst", 32'(req_dst), 32'h0200);
            tick();
        end
        cmd_valid = 1'b1;
        tick();
        tick();
        check_eq("t2_still_full", 32'(cmd_ready), 32'd0);
        req_ready = 1'b1;
        push(8'h15, 16'h0105, 16'h0, 16'h0, 16'h0205, 16'd1);
        wait_done(base + 6, "t2_all_done");
        check_eq("t2_hs_count", hs_src0.size(), 32'd6);
        for (int i = 0; i < 6 && i < hs_src0.size(); i++) begin
            check_eq("t2_order", 32'(hs_src0[i]), 32'h0100 + i);
        end

        // len=0 no-op followed by len=1
        hs_src0.delete();
        hs_last.delete();
        base = done_cnt;
        resp_dly = 3;
        push(8'h20, 16'h0300, 16'h0, 16'h0, 16'h0400, 16'd0);
        push(8'h21, 16'h0310, 16'h0, 16'h0, 16'h0410, 16'd1);
        wait_done(base + 2, "t4_two_done");
        tick();
        tick();
        check_eq("t4_done_exact", done_cnt - base, 32'd2);
        check_eq("t4_hs_count", hs_src0.size(), 32'd1);
        if (hs_src0.size() > 0) begin
            check_eq("t4_src0", 32'(hs_src0[0]), 32'h0310);
            check_eq("t4_last", 32'(hs_last[0]), 32'd1);
        end

        // Address wrap
        hs_src0.delete();
        hs_last.delete();
        base = done_cnt;
        push(8'h30, 16'hFFFF, 16'h0, 16'h0, 16'h0010, 16'd2);
        wait_done(base + 1, "t5_done");
        check_eq("t5_hs_count", hs_src0.size(), 32'd2);
        if (hs_src0.size() > 1) begin
            check_eq("t5_src0_a", 32'(hs_src0[0]), 32'hFFFF);
            check_eq("t5_src0_b", 32'(hs_src0[1]), 32'h0000);
            check_eq("t5_last_a", 32'(hs_last[0]), 32'd0);
            check_eq("t5_last_b", 32'(hs_last[1]), 32'd1);
        end
        check_eq("t5_no_err", 32'(err), 32'd0);

        // Spurious done in IDLE, sticky err
        auto_vpu = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        tick();
        check_eq("t6_err_set", 32'(err), 32'd1);
        tick();
        tick();
        tick();
        check_eq("t6_err_sticky", 32'(err), 32'd1);

        // Reset mid-WAIT with a command queued behind
        push(8'h40, 16'h0500, 16'h0, 16'h0, 16'h0600, 16'd3);
        for (int i = 0; i < 20 && !req_valid; i++) tick();
        check_eq("t6_issue", 32'(req_valid), 32'd1);
        tick();
        check_eq("t6_in_wait", 32'(req_valid), 32'd0);
        push(8'h41, 16'h0510, 16'h0, 16'h0, 16'h0610, 16'd1);
        check_eq("t6_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_eq("t6_rst_valid", 32'(req_valid), 32'd0);
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_err", 32'(err), 32'd0);
        check_eq("t6_rst_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t6_post_ready", 32'(cmd_ready), 32'd1);
        check_eq("t6_post_busy", 32'(busy), 32'd0);
        check_eq("t6_post_valid", 32'(req_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
